serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
Bit-serial adder controller. It shares one full-adder slice, built from two half-adder cells, between two requesters. It arbitrates round-robin, sequences the slice LSB-first over WIDTH cycles, and returns the sum and carry through a valid/ready result port. It sits behind the tile top-level wrapper, which maps the requester and result signals onto the ui/uo/uio pins.

Parameters:
WIDTH, 8, operand and sum width in bits (2..32)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_ready  output  1  one-cycle pulse: requester 0 operands captured
req1_valid  input  1  requester 1 has an operand pair
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_ready  output  1  one-cycle pulse: requester 1 operands captured
res_valid  output  1  result available
res_sum  output  WIDTH  sum bits
res_carry  output  1  carry out of MSB
res_id  output  1  requester that owns the result
res_ready  input  1  consumer accepts the result
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge. There is no asynchronous path.
- Reset values: state=IDLE; all outputs 0; internal carry=0; last_grant=1, so requester 0 wins first.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any reqN_valid is high, grant one requester.
  - If only one is valid, grant that one.
  - If both are valid, grant the one that is not last_grant.
  - On grant: the grantee's reqN_ready is high for that cycle only. Capture a/b into shift registers, set res_id=grantee, last_grant=grantee, carry=cin (0), bit counter=0, go to RUN.
- RUN, one bit per cycle:
  - ha0 = a[0]^b[0].
  - s = ha0 ^ carry.
  - carry_next = (a[0]&b[0]) | (ha0&carry).
  - s is shifted into res_sum from the MSB side. Operand registers shift right.
  - After WIDTH RUN cycles: res_carry=carry_next, go to DONE.
- DONE: res_valid=1. res_sum, res_carry and res_id are held stable until res_ready=1. On handshake: res_valid drops next cycle, go to IDLE.
  - A new grant can occur no earlier than the cycle after the handshake.
- Latency: grant in cycle T gives res_valid high from cycle T+WIDTH+1. Throughput is one operation per WIDTH+2 cycles with res_ready tied high.
- Requests while busy: both reqN_ready stay 0. Requesters must hold valid and operands until the ready pulse.
- res_sum is only meaningful while res_valid=1. The shift path is not zeroed between operations.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is reported only via res_carry.
- Reset mid-operation: the current operation is aborted and no result is emitted. The next cycle shows reset values; arbitration restarts with requester 0 preferred.
- A valid request dropped before its grant is not an error, and the other requester may win.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds ports req0_sub and req1_sub (input, 1 bit each), captured at grant.
  - When sub=1: operand B is inverted bitwise at capture and cin=1, so res_sum=A-B mod 2^WIDTH.
  - res_carry=1 means no borrow (A>=B).
- Not defined: the ports are absent and cin is always 0.

Decomposition:
- Package serial_add_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - requester ID constants REQ0=1'b0, REQ1=1'b1;
  - default WIDTH constant.
- Sub-module half_adder_cell: combinational, inputs a and b, outputs s=a^b and c=a&b.
  - Instantiated twice to form the slice; the full-adder carry is the OR of the two c outputs.
- Bit counter width: $clog2(WIDTH+1).

Test Plan:
1. WIDTH=8, req0 only, a=0x5A, b=0x33 -> req0_ready pulse at grant T; res_valid at T+9; res_sum=0x8D, res_carry=0, res_id=0.
2. req1 only, a=0xFF, b=0x01 -> res_sum=0x00, res_carry=1, res_id=1.
3. Both valid after reset, res_ready=1 -> requester 0 served, then requester 1. A third simultaneous pair alternates back to requester 0; req1_ready stays low while busy.
4. res_ready held 0 for 5 cycles in DONE -> res_valid, res_sum, res_carry and res_id stay stable and no ready pulses occur; release -> IDLE next cycle.
5. rst asserted during the 4th RUN cycle -> next cycle all outputs 0 and state IDLE; no res_valid ever appears for the aborted operation.
6. With SERIAL_ADD_SUB_EN defined -> 0x10-0x01 gives res_sum=0x0F, res_carry=1; 0x01-0x02 gives res_sum=0xFF, res_carry=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
//   state_e       : controller states (idle, shifting, result held)
//   REQ0 / REQ1   : requester identifiers as carried on res_id
//   DEFAULT_WIDTH : default operand width
package serial_add_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_adder_cell.sv
// Combinational half adder; two of these plus an OR form the full-adder slice.
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller. Two requesters share one full-adder slice; a
// round-robin arbiter picks one, the operands are added LSB-first over WIDTH
// cycles and the result is offered on a valid/ready port.
//
// Optional feature (macro SERIAL_ADD_SUB_EN): adds req0_sub / req1_sub. When
// set at grant, B is inverted on capture and the carry-in is 1, giving A-B;
// res_carry=1 then means no borrow.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/_a/_b         : requester N operand pair (N = 0, 1)
//   reqN_sub                 : requester N subtract select (macro only)
//   reqN_ready               : one-cycle pulse when requester N is captured
//   res_valid/_sum/_carry/_id: result, held until res_ready
//   res_ready                : consumer accepts the result
//   busy                     : high while an operation is running or held
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req0_sub,
`endif
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             last_grant_q;
    logic [CntW-1:0]  cnt_q;

    logic             grant;
    logic             grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_sub;

    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_s;
    logic             ha1_c;
    logic             carry_next;

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        grant_id = REQ0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end
    end

    // Gated by rst so no ready pulse is shown for a grant that reset discards.
    assign grant      = (state_q == StIdle) && (req0_valid || req1_valid) && !rst;
    assign req0_ready = grant && (grant_id == REQ0);
    assign req1_ready = grant && (grant_id == REQ1);
    assign busy       = (state_q != StIdle);

    always_comb begin
        sel_a = (grant_id == REQ1) ? req1_a : req0_a;
        sel_b = (grant_id == REQ1) ? req1_b : req0_b;
`ifdef SERIAL_ADD_SUB_EN
        sel_sub = (grant_id == REQ1) ? req1_sub : req0_sub;
`else
        sel_sub = 1'b0;
`endif
    end

    // Full-adder slice on the operand LSBs.
    half_adder_cell u_ha0 (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder_cell u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (ha1_s),
        .c (ha1_c)
    );

    assign carry_next = ha0_c | ha1_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            last_grant_q <= REQ1;
            cnt_q        <= '0;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_carry    <= 1'b0;
            res_id       <= REQ0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        a_q          <= sel_a;
                        b_q          <= sel_sub ? ~sel_b : sel_b;
                        carry_q      <= sel_sub;
                        res_id       <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= '0;
                        state_q      <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_next;
                    // Sum bits enter at the MSB; after WIDTH shifts bit 0 is at the LSB.
                    res_sum <= {ha1_s, res_sum[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        res_carry <= carry_next;
                        res_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=8): directed table,
// multi-cycle corner sequences (stall, reset mid-run) and randomized traffic
// against a plain-arithmetic reference model.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic [W-1:0] res_sum;
    logic         res_carry;
    logic         res_id;
    logic         res_ready;
    logic         busy;
`ifdef SERIAL_ADD_SUB_EN
    logic         req0_sub;
    logic         req1_sub;
    localparam bit SubEn = 1'b1;
`else
    localparam bit SubEn = 1'b0;
`endif

    int total;
    int bad;
    int cyc;
    logic m_last;

    serial_add_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef SERIAL_ADD_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef SERIAL_ADD_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic         v0;
        logic         v1;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic         s0;
        logic         s1;
        int           stall;
        logic         hold;
        logic         exp_id;
        logic [W-1:0] exp_sum;
        logic         exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A + B, or A + ~B + 1 (= A + 2^W - B) when subtracting; carry is bit W.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        longint unsigned ta;
        longint unsigned tb;
        longint unsigned t;
        ta = 64'(a);
        tb = 64'(b);
        if (sub) t = ta + (64'd1 << W) - tb;
        else     t = ta + tb;
        return t[W:0];
    endfunction

    // Entered just after a negedge with the DUT idle; returns just after the
    // negedge of the idle cycle that follows the result handshake.
    task automatic run_op(input logic v0, input logic v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic s0, input logic s1,
                          input logic exp_id, input logic [W-1:0] exp_sum, input logic exp_c,
                          input int stall, input logic hold, input string tag);
        int   t_grant;
        int   waited;
        int   held;
        bit   done;
        logic keep0;
        logic keep1;
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
`ifdef SERIAL_ADD_SUB_EN
        req0_sub   = s0;
        req1_sub   = s1;
`else
        if (s0 || s1) $display("note: subtract requested without SERIAL_ADD_SUB_EN (%s)", tag);
`endif
        res_ready  = 1'b0;
        #1;
        chk({tag, ".ready0"}, 64'(req0_ready), 64'(exp_id == 1'b0));
        chk({tag, ".ready1"}, 64'(req1_ready), 64'(exp_id == 1'b1));
        t_grant = cyc;
        keep0 = hold && v0 && (exp_id == 1'b1);
        keep1 = hold && v1 && (exp_id == 1'b0);
        @(negedge clk);
        if (!keep0) req0_valid = 1'b0;
        if (!keep1) req1_valid = 1'b0;
        waited = 0;
        held   = 0;
        done   = 1'b0;
        while (!done) begin
            #1;
            if (keep0 || keep1) begin
                chk({tag, ".busy_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
            end
            if (res_valid) begin
                if (held == 0) chk({tag, ".latency"}, 64'(cyc - t_grant), 64'(W + 1));
                chk({tag, ".sum"},   64'(res_sum),   64'(exp_sum));
                chk({tag, ".carry"}, 64'(res_carry), 64'(exp_c));
                chk({tag, ".id"},    64'(res_id),    64'(exp_id));
                if (held >= stall) begin
                    res_ready = 1'b1;
                    done      = 1'b1;
                end
                held++;
            end
            waited++;
            if (!done && waited > int'(W) + stall + 8) begin
                chk({tag, ".timeout"}, 64'(res_valid), 64'd1);
                done = 1'b1;
            end
            @(negedge clk);
        end
        #1;
        chk({tag, ".post_hs"}, 64'({res_valid, busy}), 64'd0);
        res_ready = 1'b0;
    endtask

    logic         pv[2];
    logic [W-1:0] pa[2];
    logic [W-1:0] pb[2];
    logic         ps[2];

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        res_ready  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        req0_sub   = 1'b0;
        req1_sub   = 1'b0;
`endif
        m_last     = 1'b1;

        //          v0 v1  a0     b0     a1     b1    s0 s1 st hold id  sum    c
        vecs.push_back('{1, 0, 8'h5A, 8'h33, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h8D, 0});
        vecs.push_back('{0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 0, 0, 0, 0, 1, 8'h00, 1});
        vecs.push_back('{1, 1, 8'h12, 8'h34, 8'h80, 8'h80, 0, 0, 0, 1, 0, 8'h46, 0});
        vecs.push_back('{0, 1, 8'h00, 8'h00, 8'h80, 8'h80, 0, 0, 0, 0, 1, 8'h00, 1});
        vecs.push_back('{1, 1, 8'hC8, 8'h64, 8'h11, 8'h22, 0, 0, 0, 1, 0, 8'h2C, 1});
        vecs.push_back('{0, 1, 8'h00, 8'h00, 8'h11, 8'h22, 0, 0, 0, 0, 1, 8'h33, 0});
        vecs.push_back('{0, 1, 8'h00, 8'h00, 8'h7F, 8'h01, 0, 0, 5, 0, 1, 8'h80, 0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{1, 0, 8'h10, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h0F, 1});
        vecs.push_back('{0, 1, 8'h00, 8'h00, 8'h01, 8'h02, 0, 1, 2, 0, 1, 8'hFF, 0});
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.outputs", 64'({res_valid, res_sum, res_carry, res_id, busy}), 64'd0);
        chk("reset.ready", 64'({req0_ready, req1_ready}), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                   vecs[i].s0, vecs[i].s1, vecs[i].exp_id, vecs[i].exp_sum, vecs[i].exp_c,
                   vecs[i].stall, vecs[i].hold, $sformatf("vec%0d", i));
            m_last = vecs[i].exp_id;
        end

        // Reset during the 4th RUN cycle aborts the operation.
        req0_valid = 1'b1;
        req0_a     = 8'hAA;
        req0_b     = 8'h55;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.outputs", 64'({res_valid, res_sum, res_carry, res_id, busy}), 64'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 2 * int'(W); i++) begin
                @(negedge clk);
                #1;
                if (res_valid || busy) seen++;
            end
            chk("abort.no_result", 64'(seen), 64'd0);
        end
        // Arbitration restarts preferring requester 0.
        m_last = 1'b1;
        run_op(1, 1, 8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 8'h03, 0, 0, 0, "after_rst");
        m_last = 1'b0;

        // Randomized traffic; a losing requester may keep its request pending.
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            logic         gid;
            logic         hold;
            logic [W:0]   r;
            for (int q = 0; q < 2; q++) begin
                if (!pv[q]) begin
                    pv[q] = 1'($urandom_range(0, 1));
                    pa[q] = W'($urandom);
                    pb[q] = W'($urandom);
                    ps[q] = SubEn ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
            if (!pv[0] && !pv[1]) pv[$urandom_range(0, 1)] = 1'b1;
            gid    = (pv[0] && pv[1]) ? ~m_last : pv[1];
            m_last = gid;
            r      = ref_add(pa[gid], pb[gid], ps[gid]);
            hold   = (pv[0] && pv[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(pv[0], pv[1], pa[0], pb[0], pa[1], pb[1], ps[0], ps[1], gid, r[W-1:0], r[W],
                   $urandom_range(0, 3), hold, $sformatf("rand%0d", it));
            pv[gid] = 1'b0;
            if (!hold) pv[~gid] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
